// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Load hits return data in the request cycle; misses and stores stall the core
// while a single backing-memory transaction is in flight.
module data_cache #(
    parameter int unsigned LINES = 16,
    parameter int unsigned AW    = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          Hit,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = AW - IW - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t           state;
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic             done;

    logic [IW-1:0]    cpu_idx;
    logic [TW-1:0]    cpu_tag;
    logic [AW-1:0]    cpu_word;
    logic             cpu_hit;
    logic [IW-1:0]    mem_idx;
    logic [TW-1:0]    mem_tag;
    logic             mem_hit;
    logic             unused_addr_bits;

    // Byte-offset bits never take part in indexing or tag compare.
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign cpu_idx  = cpu_addr[IW+1:2];
    assign cpu_tag  = cpu_addr[AW-1:IW+2];
    assign cpu_word = {cpu_addr[AW-1:2], 2'b00};
    assign cpu_hit  = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);

    // The captured transaction address doubles as the line pointer for fill/update.
    assign mem_idx  = mem_addr[IW+1:2];
    assign mem_tag  = mem_addr[AW-1:IW+2];
    assign mem_hit  = valid[mem_idx] && (tag_mem[mem_idx] == mem_tag);

    // Core-facing handshake: zero-latency load hit, stall on miss, store or busy.
    always_comb begin
        Hit       = 1'b0;
        stall     = 1'b0;
        cpu_rdata = '0;
        if (RESET) begin
            if (state != IDLE) begin
                stall = 1'b1;
            end else if (cpu_req) begin
                if (cpu_we) begin
                    stall = !done;
                end else if (cpu_hit) begin
                    Hit       = 1'b1;
                    cpu_rdata = data_mem[cpu_idx];
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end

    // Controller FSM; memory request outputs are registered and held until mem_ready.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            valid     <= '0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (cpu_we) begin
                            if (!done) begin
                                state     <= WRITE;
                                mem_req   <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= cpu_word;
                                mem_wdata <= cpu_wdata;
                            end
                        end else if (!cpu_hit) begin
                            state    <= FILL;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= cpu_word;
                        end
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        valid[mem_idx] <= 1'b1;
                        mem_req        <= 1'b0;
                        state          <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays: written on fill completion or on a write-through hit.
    always_ff @(posedge CLK) begin
        if (state == FILL && mem_ready) begin
            tag_mem[mem_idx]  <= mem_tag;
            data_mem[mem_idx] <= mem_rdata;
        end else if (state == WRITE && mem_ready && mem_hit) begin
            data_mem[mem_idx] <= mem_wdata;
        end
    end

endmodule
